// File: rtl/pad_poller_pkg.sv
// Shared types and constants for the serial game-pad poller.
package pad_poller_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SETTLE,
    CLK_HI,
    CLK_LO,
    DONE,
    GAP
  } state_e;

  localparam int unsigned MIN_HALF_PERIOD = 3;
  localparam int unsigned NES_BITS        = 8;
  localparam int unsigned SNES_BITS       = 16;

  // Larger of two unsigned values, used to size the shared phase timer.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pad_poller_if.sv
// Pad-side pins and game-side results of the pad poller.
interface pad_poller_if
  import pad_poller_pkg::*;
#(
  parameter int unsigned NUM_PADS = 2,
  parameter int unsigned NUM_BITS = NES_BITS
);
  logic                         enable;
  logic [NUM_PADS-1:0]          data;
  logic                         latch;
  logic                         pad_clk;
  logic [NUM_PADS*NUM_BITS-1:0] buttons;
  logic [NUM_PADS*NUM_BITS-1:0] pressed;
  logic                         valid;
  logic                         busy;

  modport master (
    input  enable, data,
    output latch, pad_clk, buttons, pressed, valid, busy
  );

  modport slave (
    output enable, data,
    input  latch, pad_clk, buttons, pressed, valid, busy
  );
endinterface

// File: rtl/pad_sync.sv
// Two-flop synchroniser; resets to the released (high) pad level.
module pad_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;

  // Two-stage capture of the asynchronous pad lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/pad_poller.sv
// Polls NUM_PADS serial pads over a shared latch/clock and publishes
// button vectors atomically at the end of each poll.
module pad_poller
  import pad_poller_pkg::*;
#(
  parameter int unsigned NUM_PADS    = 2,
  parameter int unsigned NUM_BITS    = NES_BITS,
  parameter int unsigned HALF_PERIOD = 4,
  parameter int unsigned POLL_GAP    = 64
) (
  input  logic          clk_900KHz,
  input  logic          reset,
  pad_poller_if.master  bus
);
  localparam int unsigned TOT  = NUM_PADS * NUM_BITS;
  localparam int unsigned TMAX = max_u(2 * HALF_PERIOD, POLL_GAP);
  localparam int unsigned TW   = $clog2(TMAX);
  localparam int unsigned BW   = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

  localparam logic [TW-1:0] T_LATCH = TW'(2 * HALF_PERIOD - 1);
  localparam logic [TW-1:0] T_HALF  = TW'(HALF_PERIOD - 1);
  localparam logic [TW-1:0] T_GAP   = TW'(POLL_GAP - 1);
  localparam logic [BW-1:0] B_LAST  = BW'(NUM_BITS - 1);

  state_e              state;
  logic [TW-1:0]       timer;
  logic [BW-1:0]       bit_idx;
  logic [NUM_PADS-1:0] sync_q;
  logic [TOT-1:0]      shadow;
  logic                sample_c;

  pad_sync #(.WIDTH(NUM_PADS)) u_sync (
    .clk (clk_900KHz),
    .rst (reset),
    .d   (bus.data),
    .q   (sync_q)
  );

  // A bit is taken on the last cycle of SETTLE (bit 0) and of each CLK_LO.
  always_comb begin
    sample_c = ((state == SETTLE) || (state == CLK_LO)) && (timer == T_HALF);
  end

  // Per-pad shadow lane; inverted because pad data is active-low.
  for (genvar g = 0; g < NUM_PADS; g++) begin : g_lane
    logic [NUM_BITS-1:0] lane;

    // Capture the current bit of this pad into its lane.
    always_ff @(posedge clk_900KHz or posedge reset) begin
      if (reset) begin
        lane <= '0;
      end else if (sample_c) begin
        lane[bit_idx] <= ~sync_q[g];
      end
    end

    assign shadow[g*NUM_BITS +: NUM_BITS] = lane;
  end

  // Poll sequencer with registered pin and result outputs.
  always_ff @(posedge clk_900KHz or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      bit_idx     <= '0;
      bus.latch   <= 1'b0;
      bus.pad_clk <= 1'b0;
      bus.busy    <= 1'b0;
      bus.valid   <= 1'b0;
      bus.buttons <= '0;
      bus.pressed <= '0;
    end else begin
      bus.latch   <= (state == LATCH);
      bus.pad_clk <= (state == CLK_HI);
      bus.busy    <= (state == LATCH) || (state == SETTLE) || (state == CLK_HI) ||
                     (state == CLK_LO) || (state == DONE);
      bus.valid   <= (state == DONE);
      bus.pressed <= '0;

      case (state)
        IDLE: begin
          if (bus.enable) begin
            state   <= LATCH;
            timer   <= '0;
            bit_idx <= '0;
          end
        end
        LATCH: begin
          if (timer == T_LATCH) begin
            state <= SETTLE;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        SETTLE: begin
          if (timer == T_HALF) begin
            state   <= CLK_HI;
            timer   <= '0;
            bit_idx <= bit_idx + 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        CLK_HI: begin
          if (timer == T_HALF) begin
            state <= CLK_LO;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        CLK_LO: begin
          if (timer == T_HALF) begin
            timer <= '0;
            if (bit_idx == B_LAST) begin
              state <= DONE;
            end else begin
              state   <= CLK_HI;
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DONE: begin
          bus.buttons <= shadow;
          bus.pressed <= shadow & ~bus.buttons;
          state       <= GAP;
          timer       <= '0;
        end
        GAP: begin
          if (timer == T_GAP) begin
            state   <= bus.enable ? LATCH : IDLE;
            timer   <= '0;
            bit_idx <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pad_poller.sv
// Bench for pad_poller: an NES instance (2 pads x 8 bits) and an SNES
// instance (1 pad x 16 bits) driven by behavioural pad models.
module tb_pad_poller;
  import pad_poller_pkg::*;

  localparam int unsigned H  = 4;
  localparam int unsigned NG = 64;
  localparam int unsigned SG = 16;
  // Poll length in cycles: latch 2H, settle H, (N-1) clock periods, DONE, gap.
  localparam int NES_PERIOD = int'(2*H + H + (NES_BITS-1)*2*H + 1 + NG);
  // Ticks from raising enable in IDLE until valid is seen (first tick sees edge t0).
  localparam int NES_LAT  = int'(3*H + (NES_BITS-1)*2*H + 2);
  localparam int SNES_LAT = int'(3*H + (SNES_BITS-1)*2*H + 2);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  pad_poller_if #(.NUM_PADS(2), .NUM_BITS(NES_BITS))  n_if ();
  pad_poller_if #(.NUM_PADS(1), .NUM_BITS(SNES_BITS)) s_if ();

  pad_poller #(.NUM_PADS(2), .NUM_BITS(NES_BITS), .HALF_PERIOD(H), .POLL_GAP(NG)) u_nes (
    .clk_900KHz (clk),
    .reset      (rst),
    .bus        (n_if)
  );

  pad_poller #(.NUM_PADS(1), .NUM_BITS(SNES_BITS), .HALF_PERIOD(H), .POLL_GAP(SG)) u_snes (
    .clk_900KHz (clk),
    .reset      (rst),
    .bus        (s_if)
  );

  // Pad models: pressed buttons (1) drive the line low; latch loads, pad_clk shifts.
  logic [7:0]  nes_pat [2];
  logic [7:0]  nes_sr  [2];
  logic [15:0] snes_pat;
  logic [15:0] snes_sr;

  always @(posedge n_if.latch or posedge n_if.pad_clk) begin
    if (n_if.latch) begin
      nes_sr[0] = nes_pat[0];
      nes_sr[1] = nes_pat[1];
    end else begin
      nes_sr[0] = nes_sr[0] >> 1;
      nes_sr[1] = nes_sr[1] >> 1;
    end
  end

  always @(posedge s_if.latch or posedge s_if.pad_clk) begin
    if (s_if.latch) snes_sr = snes_pat;
    else            snes_sr = snes_sr >> 1;
  end

  assign n_if.data = {~nes_sr[1][0], ~nes_sr[0][0]};
  assign s_if.data = ~snes_sr[0];

  // Activity monitor: edge counts, latch widths, valid timestamps.
  int   cyc = 0;
  int   n_edges = 0, n_lat_len = 0, n_lat_rises = 0, n_valid_cnt = 0, n_stray = 0;
  int   n_last_v = 0, n_prev_v = 0;
  int   s_edges = 0, s_lat_len = 0, s_valid_cnt = 0;
  logic n_lat_p = 1'b0, n_clk_p = 1'b0, s_lat_p = 1'b0, s_clk_p = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (n_if.latch && !n_lat_p) begin n_edges = 0; n_lat_len = 0; n_lat_rises++; end
    if (n_if.latch) n_lat_len++;
    if (n_if.pad_clk && !n_clk_p) n_edges++;
    if (n_if.valid) begin n_valid_cnt++; n_prev_v = n_last_v; n_last_v = cyc; end
    if (!n_if.valid && (n_if.pressed != '0)) n_stray++;
    if (s_if.latch && !s_lat_p) begin s_edges = 0; s_lat_len = 0; end
    if (s_if.latch) s_lat_len++;
    if (s_if.pad_clk && !s_clk_p) s_edges++;
    if (s_if.valid) s_valid_cnt++;
    n_lat_p = n_if.latch; n_clk_p = n_if.pad_clk;
    s_lat_p = s_if.latch; s_clk_p = s_if.pad_clk;
  end

  logic [15:0] n_model;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_nes_valid(input int budget, output int n, output bit ok);
    n = 0; ok = 1'b0;
    while (n < budget && !ok) begin tick(); n++; if (n_if.valid) ok = 1'b1; end
  endtask

  task automatic wait_snes_valid(input int budget, output int n, output bit ok);
    n = 0; ok = 1'b0;
    while (n < budget && !ok) begin tick(); n++; if (s_if.valid) ok = 1'b1; end
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1; n_if.enable = 1'b0; s_if.enable = 1'b0;
    nes_pat[0] = '0; nes_pat[1] = '0; snes_pat = '0;
    nes_sr[0] = '0; nes_sr[1] = '0; snes_sr = '0;
    repeat (3) tick();
    n_vec++;
    if ({n_if.latch, n_if.pad_clk, n_if.valid, n_if.busy, s_if.latch, s_if.busy} !== 6'b0) begin
      n_err++; $display("FAIL reset_pins: got %b want 000000",
        {n_if.latch, n_if.pad_clk, n_if.valid, n_if.busy, s_if.latch, s_if.busy});
    end
    rst = 1'b0;
    bad = 0;
    repeat (200) begin
      tick();
      if (n_if.latch || n_if.pad_clk || n_if.busy || s_if.latch || s_if.pad_clk) bad++;
    end
    n_vec++;
    if (bad !== 0) begin n_err++; $display("FAIL idle_pins: %0d active cycles, want 0", bad); end
    n_vec++;
    if (n_valid_cnt + s_valid_cnt !== 0) begin
      n_err++; $display("FAIL idle_valid: %0d pulses, want 0", n_valid_cnt + s_valid_cnt);
    end
    n_vec++;
    if (n_if.buttons !== 16'h0 || s_if.buttons !== 16'h0 || n_if.pressed !== 16'h0) begin
      n_err++; $display("FAIL idle_buttons: nes %h snes %h pressed %h, want 0",
        n_if.buttons, s_if.buttons, n_if.pressed);
    end
    n_model = '0;
  endtask

  task automatic test_snes();
    int n; bit ok;
    snes_pat = 16'hA5C3;
    s_if.enable = 1'b1;
    tick();
    s_if.enable = 1'b0;
    wait_snes_valid(400, n, ok);
    n_vec++;
    if (!ok || (n + 1) !== SNES_LAT) begin
      n_err++; $display("FAIL snes_latency: got %0d (seen %0d) want %0d", n + 1, ok, SNES_LAT);
    end
    n_vec++;
    if (s_if.buttons !== 16'hA5C3 || s_if.pressed !== 16'hA5C3) begin
      n_err++; $display("FAIL snes_data: buttons %h pressed %h want a5c3", s_if.buttons, s_if.pressed);
    end
    n_vec++;
    if (s_edges !== 15 || s_lat_len !== int'(2*H)) begin
      n_err++; $display("FAIL snes_timing: edges %0d latch %0d want 15 / %0d", s_edges, s_lat_len, 2*H);
    end
  endtask

  task automatic test_nes_single();
    int n; bit ok;
    nes_pat[0] = 8'h81; nes_pat[1] = 8'h08;
    n_if.enable = 1'b1;
    wait_nes_valid(300, n, ok);
    n_vec++;
    if (!ok || n !== NES_LAT) begin
      n_err++; $display("FAIL nes_latency: got %0d (seen %0d) want %0d", n, ok, NES_LAT);
    end
    n_vec++;
    if (n_if.buttons !== 16'h0881 || n_if.pressed !== 16'h0881 || n_if.busy !== 1'b1) begin
      n_err++; $display("FAIL nes_data: buttons %h pressed %h busy %b want 0881 0881 1",
        n_if.buttons, n_if.pressed, n_if.busy);
    end
    n_vec++;
    if (n_edges !== 7 || n_lat_len !== int'(2*H)) begin
      n_err++; $display("FAIL nes_timing: edges %0d latch %0d want 7 / %0d", n_edges, n_lat_len, 2*H);
    end
    tick();
    n_vec++;
    if (n_if.valid !== 1'b0 || n_if.pressed !== 16'h0 || n_if.busy !== 1'b0) begin
      n_err++; $display("FAIL nes_after_done: valid %b pressed %h busy %b want 0",
        n_if.valid, n_if.pressed, n_if.busy);
    end
    n_model = 16'h0881;
  endtask

  task automatic test_edge_detect();
    int n; bit ok;
    nes_pat[0] = 8'h01;
    wait_nes_valid(NES_PERIOD + 20, n, ok);
    n_vec++;
    if (!ok || (n_last_v - n_prev_v) !== NES_PERIOD) begin
      n_err++; $display("FAIL poll_period: got %0d (seen %0d) want %0d", n_last_v - n_prev_v, ok, NES_PERIOD);
    end
    n_vec++;
    if (n_if.buttons !== 16'h0801 || n_if.pressed !== 16'h0) begin
      n_err++; $display("FAIL release: buttons %h pressed %h want 0801 0000", n_if.buttons, n_if.pressed);
    end
    nes_pat[0] = 8'h03;
    wait_nes_valid(NES_PERIOD + 20, n, ok);
    n_vec++;
    if (!ok || n_if.pressed !== 16'h0002 || n_if.buttons !== 16'h0803) begin
      n_err++; $display("FAIL press_b: pressed %h buttons %h (seen %0d) want 0002 0803",
        n_if.pressed, n_if.buttons, ok);
    end
    tick();
    n_vec++;
    if (n_if.pressed !== 16'h0) begin
      n_err++; $display("FAIL press_width: pressed %h a cycle later, want 0000", n_if.pressed);
    end
    n_model = 16'h0803;
  endtask

  task automatic test_back_to_back();
    int n; bit ok;
    logic [15:0] exp_btn, exp_prs;
    for (int i = 0; i < 6; i++) begin
      nes_pat[0] = 8'($urandom);
      nes_pat[1] = (i == 2) ? 8'h00 : 8'($urandom);
      exp_btn = {nes_pat[1], nes_pat[0]};
      exp_prs = exp_btn & ~n_model;
      wait_nes_valid(NES_PERIOD + 20, n, ok);
      n_vec++;
      if (!ok || n_if.buttons !== exp_btn || n_if.pressed !== exp_prs ||
          (n_last_v - n_prev_v) !== NES_PERIOD) begin
        n_err++; $display("FAIL random_poll%0d: buttons %h pressed %h period %0d want %h %h %0d",
          i, n_if.buttons, n_if.pressed, n_last_v - n_prev_v, exp_btn, exp_prs, NES_PERIOD);
      end
      n_model = exp_btn;
    end
    n_vec++;
    if (n_stray !== 0) begin n_err++; $display("FAIL stray_pressed: %0d cycles want 0", n_stray); end
  endtask

  task automatic test_enable_drop();
    int n, v0, l0; bit ok, found;
    nes_pat[0] = 8'h5A; nes_pat[1] = 8'hC3;
    found = 1'b0; n = 0;
    while (n < 400 && !found) begin
      tick(); n++;
      if (n_if.pad_clk && n_edges == 3) found = 1'b1;
    end
    n_if.enable = 1'b0;
    wait_nes_valid(300, n, ok);
    n_vec++;
    if (!found || !ok || n_if.buttons !== 16'hC35A || n_if.pressed !== (16'hC35A & ~n_model)) begin
      n_err++; $display("FAIL drop_poll: buttons %h pressed %h (found %0d seen %0d) want c35a %h",
        n_if.buttons, n_if.pressed, found, ok, 16'hC35A & ~n_model);
    end
    n_model = 16'hC35A;
    v0 = n_valid_cnt; l0 = n_lat_rises;
    repeat (NG + 100) tick();
    n_vec++;
    if (n_valid_cnt !== v0 || n_lat_rises !== l0 || n_if.busy !== 1'b0) begin
      n_err++; $display("FAIL drop_idle: valid +%0d latch +%0d busy %b want 0 0 0",
        n_valid_cnt - v0, n_lat_rises - l0, n_if.busy);
    end
    n_if.enable = 1'b1;
    wait_nes_valid(300, n, ok);
    n_vec++;
    if (!ok || n !== NES_LAT || n_if.pressed !== 16'h0) begin
      n_err++; $display("FAIL restart_from_idle: latency %0d pressed %h want %0d 0000",
        n, n_if.pressed, NES_LAT);
    end
  endtask

  task automatic test_reset_mid();
    int n, v0; bit found;
    found = 1'b0; n = 0;
    while (n < 300 && !found) begin tick(); n++; if (n_if.latch) found = 1'b1; end
    n = 0;
    while (n < 300 && found && !(n_edges == 5 && !n_if.pad_clk)) begin tick(); n++; end
    rst = 1'b1;
    #1;
    n_vec++;
    if (!found || n >= 300 || {n_if.latch, n_if.pad_clk, n_if.busy} !== 3'b0 || n_if.buttons !== 16'h0) begin
      n_err++; $display("FAIL abort_async: latch/clk/busy %b buttons %h (found %0d) want 000 0000",
        {n_if.latch, n_if.pad_clk, n_if.busy}, n_if.buttons, found);
    end
    n_if.enable = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    v0 = n_valid_cnt;
    repeat (150) tick();
    n_vec++;
    if (n_valid_cnt !== v0 || n_if.buttons !== 16'h0 || n_if.latch !== 1'b0) begin
      n_err++; $display("FAIL abort_quiet: valid +%0d buttons %h latch %b want 0 0000 0",
        n_valid_cnt - v0, n_if.buttons, n_if.latch);
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_snes();
    test_nes_single();
    test_edge_detect();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pad_poller.md
Name: pad_poller

Overview:
- Parametrised successor to the single NES pad interface. Polls NUM_PADS serial game pads over one shared latch and one shared clock, and shifts NUM_BITS bits per pad (8 for NES, 16 for SNES).
- Presents per-pad button vectors that update atomically at the end of each poll. Emits a poll-done strobe and per-button press-edge pulses.
- Sits between the pad connector pins and game logic, replacing the free-running divider and shift-register pair with a timed, self-pacing FSM.

Parameters:
- NUM_PADS, 2, number of pads on the shared latch/clock; legal range 1..4.
- NUM_BITS, 8, bits shifted per pad; 8 for NES, 16 for SNES.
- HALF_PERIOD, 4, system-clock cycles per half period of pad_clk; minimum 3.
- POLL_GAP, 64, idle cycles between the end of one poll and the next latch; minimum 1.

Ports:
- clk_900KHz  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  level; allows polling to start and continue.
- data  input  NUM_PADS  serial data from each pad, active-low; bit p comes from pad p.
- latch  output  1  pad latch, active-high.
- pad_clk  output  1  shared pad shift clock; idles low.
- buttons  output  NUM_PADS*NUM_BITS  pressed=1; pad p occupies [p*NUM_BITS +: NUM_BITS]; bit 0 is the first bit shifted (A on NES, B on SNES).
- pressed  output  NUM_PADS*NUM_BITS  one-cycle pulse per button on a 0->1 transition between consecutive polls.
- valid  output  1  one-cycle pulse when buttons/pressed update.
- busy  output  1  high from the first latch cycle through the DONE state.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0, synchronisers cleared. Reset asserted mid-poll aborts it immediately; no partial update of buttons.
- Input path: each data bit passes through a two-flop synchroniser, then is inverted. Sampling points leave at least HALF_PERIOD-2 cycles of settle after the last pad_clk/latch edge.
- FSM states:
  - IDLE: outputs held. If enable=1, go to LATCH next cycle.
  - LATCH: latch=1 for 2*HALF_PERIOD cycles.
  - SETTLE: latch=0, pad_clk=0 for HALF_PERIOD cycles. On the last cycle, sample bit 0 of every pad.
  - CLK_HI: pad_clk=1 for HALF_PERIOD cycles.
  - CLK_LO: pad_clk=0 for HALF_PERIOD cycles. On the last cycle, sample bit k of every pad. If k<NUM_BITS-1, increment k and return to CLK_HI; else go to DONE.
  - DONE: one cycle. buttons <= shadow; pressed <= shadow & ~buttons_old; valid=1.
  - GAP: POLL_GAP cycles. Then go to LATCH if enable=1, else IDLE.
- pad_clk rising edges per poll: exactly NUM_BITS-1.
- Latency: with enable high at edge t0 in IDLE, latch is high from t0+1 through t0+2H. The last sample falls at t0+3H+(NUM_BITS-1)*2H. valid is high at the next cycle. For H=4, N=8: valid at t0+69.
- Samples accumulate in a shadow register. buttons never shows a mix of two polls.
- enable deasserted mid-poll: the current poll completes including DONE, then GAP, then IDLE. enable has no effect in GAP except the exit decision.
- Disconnected pad: data is pulled high, so every button reads 0 and no pressed pulses fire.
- pressed: pulses only in the DONE cycle, otherwise 0. The first poll after reset compares against all-zero buttons.
- Counters are sized $clog2 of their maximum and must not wrap within a state.

Decomposition:
- pad_poller_pkg holds the state enum (IDLE, LATCH, SETTLE, CLK_HI, CLK_LO, DONE, GAP) and the constants MIN_HALF_PERIOD=3, NES_BITS=8, SNES_BITS=16.
- One sub-module: pad_sync, a two-flop synchroniser with a width parameter and async reset to 1 (released level). It is instantiated once, NUM_PADS wide.

Test Plan:
- Reset/idle: reset high, then low with enable=0 for 200 cycles -> latch=0, pad_clk=0, buttons=0, valid never pulses.
- NES single poll (H=4, N=8, 2 pads): pad model drives A and Right pressed on pad0 and only Start on pad1, enable at t0 -> valid at t0+69; buttons[7:0]=8'h81, buttons[15:8]=8'h08; pressed equals buttons; exactly 7 pad_clk rising edges.
- Edge detect: second poll with pad0 now only A -> pressed all 0, buttons[7:0]=8'h01. Third poll adds B -> pressed[1]=1 for exactly one cycle.
- SNES mode (N=16): pad drives 16'hA5C3 pressed pattern -> buttons[15:0]=16'hA5C3; 15 clock edges; latch width 2H.
- Enable drop mid-poll: deassert enable during CLK_HI of bit 3 -> poll completes, valid pulses once, no further latch after GAP, state returns to IDLE.
- Reset mid-poll: assert reset during CLK_LO of bit 5 -> latch/pad_clk/busy go 0 asynchronously, buttons stay 0, valid does not pulse.
